req_gnt_monitor: RTL and testbench
==================================

REQ_GNT_MONITOR -- requirements
Module: req_gnt_monitor

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent req/gnt channels (1..32).
REQ-002 Parameter MIN_LAT, default 3: minimum legal req-to-gnt latency in cycles (0..MAX_LAT).
REQ-003 Parameter MAX_LAT, default 5: maximum legal req-to-gnt latency in cycles (>=1).
REQ-004 Parameter CNT_W, default 16: width of the statistics counters.
REQ-005 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 req  input  NUM_CH  per-channel request.
REQ-008 gnt  input  NUM_CH  per-channel grant.
REQ-009 busy  output  NUM_CH  channel has an outstanding request (WAIT state).
REQ-010 pass  output  NUM_CH  one-cycle pulse: grant arrived within [MIN_LAT, MAX_LAT].
REQ-011 err_early  output  NUM_CH  one-cycle pulse: grant latency was below MIN_LAT.
REQ-012 err_timeout  output  NUM_CH  one-cycle pulse: no grant by MAX_LAT.
REQ-013 err_spurious  output  NUM_CH  one-cycle pulse: grant seen with no request outstanding and req low.
REQ-014 err_sticky  output  NUM_CH  OR of all error pulses per channel, held until reset.
REQ-015 pass_cnt, fail_cnt  output  CNT_W each  total pass and error events across all channels (present only under REQ-032).

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE and WAIT, plus a latency counter of width $clog2(MAX_LAT+1).
REQ-017 Latency k SHALL be defined as the cycle of the gnt sample minus the cycle in which req was sampled high in IDLE.
REQ-018 In IDLE with req high, gnt low: the FSM SHALL move to WAIT with the counter at 1 on the next cycle.
REQ-019 In IDLE with req and gnt both high: if MIN_LAT==0, pass SHALL be pulsed; otherwise err_early SHALL be pulsed. In both cases the FSM SHALL remain in IDLE.
REQ-020 In IDLE with req low and gnt high: err_spurious SHALL be pulsed.
REQ-021 In WAIT with gnt high: pass SHALL be pulsed if MIN_LAT<=k<=MAX_LAT, else err_early; the FSM SHALL then return to IDLE.
REQ-022 In WAIT with gnt low and k==MAX_LAT: err_timeout SHALL be pulsed and the FSM SHALL return to IDLE.
REQ-023 A grant at exactly k==MAX_LAT SHALL count as pass, not timeout.
REQ-024 req while in WAIT SHALL be ignored; requests are not queued and a channel re-arms only from IDLE.
REQ-025 All pulse outputs SHALL be registered and assert in the cycle after the deciding sample; at most one of pass/err_* per channel per cycle.
REQ-026 busy SHALL equal (state==WAIT), registered.
REQ-027 When enabled, the counters SHALL add the popcount of pass and of (err_early|err_timeout|err_spurious) each cycle, saturating at all-ones with no wrap.

Reset
REQ-028 While reset==0 at a rising edge, all FSMs SHALL go to IDLE, the latency counters and all outputs SHALL go to 0, and err_sticky and the statistics counters SHALL be cleared.
REQ-029 A reset asserted mid-WAIT SHALL abandon the request without any pulse; monitoring SHALL resume on the first edge with reset==1.

Configuration
REQ-030 The macro REQ_GNT_MONITOR_STATS_EN SHALL select the statistics counters.
REQ-031 Without the macro, pass_cnt and fail_cnt SHALL be absent from the port list and no counter logic SHALL be built.
REQ-032 With the macro defined, pass_cnt and fail_cnt SHALL exist and behave per REQ-027.

Structure
REQ-033 Package req_gnt_mon_pkg SHALL hold the ch_state_e enum (IDLE, WAIT) and the result_e enum (NONE, PASS, EARLY, TIMEOUT, SPURIOUS).
REQ-034 Per-channel logic SHALL live in sub-module req_gnt_mon_ch, instantiated NUM_CH times by a generate loop; the top holds the sticky and statistics logic only.

Verification (NUM_CH=3, MIN_LAT=3, MAX_LAT=5, STATS_EN defined)
REQ-035 req[0] high 1 cycle at T, gnt[0] pulse at T+4 -> pass[0] at T+5, busy[0] high T+1..T+4, pass_cnt=1.
REQ-036 req[1] at T, gnt[1] at T+1 -> err_early[1] at T+2, err_sticky[1]=1, fail_cnt=1.
REQ-037 req[2] at T, no gnt -> err_timeout[2] at T+6; gnt[2] at T+5 instead -> pass[2] at T+6.
REQ-038 gnt[0] high with req[0] low in IDLE -> err_spurious[0] next cycle; req[0] and gnt[0] high together -> err_early[0].
REQ-039 All three channels pass in the same cycle -> pass_cnt increments by 3. Force pass_cnt to 16'hFFFF, then another pass -> pass_cnt stays 16'hFFFF.
REQ-040 reset low during WAIT at T+2 -> no pulse, busy and err_sticky cleared; a new req after release is monitored normally.

Source files
------------

// File: rtl/req_gnt_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : req_gnt_mon_pkg
// Description : Shared types and helpers for the req/gnt latency monitor:
//               per-channel FSM states, per-sample result codes and a
//               popcount helper used by the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package req_gnt_mon_pkg;

    // Per-channel monitor state: waiting for a request, or waiting for its grant
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_e;

    // Outcome decided by one sample of req/gnt on one channel
    typedef enum logic [2:0] {
        NONE     = 3'd0,
        PASS     = 3'd1,
        EARLY    = 3'd2,
        TIMEOUT  = 3'd3,
        SPURIOUS = 3'd4
    } result_e;

    // Number of set bits in a vector of up to 32 channels (result fits 0..32)
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage : req_gnt_mon_pkg
`default_nettype wire

// File: rtl/req_gnt_mon_ch.sv
`default_nettype none
// ============================================================================
// Module      : req_gnt_mon_ch
// Description : One req/gnt channel checker. Measures the latency from a
//               request accepted in IDLE to its grant and reports exactly one
//               registered outcome per decided sample (pass / early /
//               timeout / spurious grant).
// Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_mon_ch
    import req_gnt_mon_pkg::*;
#(
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 5
) (
    input  logic clk,
    input  logic reset,          // synchronous, active-low
    input  logic i_req,
    input  logic i_gnt,
    output logic o_busy,
    output logic o_pass,
    output logic o_err_early,
    output logic o_err_timeout,
    output logic o_err_spurious
);

    localparam int                 c_LAT_W   = $clog2(MAX_LAT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE = c_LAT_W'(1);

    ch_state_e          r_state;
    logic [c_LAT_W-1:0] r_lat;      // cycles elapsed since the request was taken
    result_e            r_result;   // outcome of the previous sample, one cycle wide

    // Channel FSM: tracks the outstanding request and registers the outcome.
    // The latency compares are done in int so a zero MIN_LAT stays a plain,
    // always-true compare instead of an unsigned ">= 0".
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_lat    <= '0;
            r_result <= NONE;
        end else begin
            r_result <= NONE;
            case (r_state)
                IDLE: begin
                    if (i_req && i_gnt) begin
                        // Zero-latency grant: only legal when the window opens at 0
                        r_result <= (MIN_LAT == 0) ? PASS : EARLY;
                    end else if (i_req) begin
                        r_state <= WAIT;
                        r_lat   <= c_LAT_ONE;
                    end else if (i_gnt) begin
                        r_result <= SPURIOUS;
                    end
                end
                WAIT: begin
                    // Requests seen here are deliberately ignored (no queueing)
                    if (i_gnt) begin
                        // r_lat never exceeds MAX_LAT here, so only the low bound matters
                        r_result <= (int'(r_lat) >= MIN_LAT) ? PASS : EARLY;
                        r_state  <= IDLE;
                        r_lat    <= '0;
                    end else if (int'(r_lat) >= MAX_LAT) begin
                        r_result <= TIMEOUT;
                        r_state  <= IDLE;
                        r_lat    <= '0;
                    end else begin
                        r_lat <= r_lat + c_LAT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_lat   <= '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so they are glitch-free and one-hot
    assign o_busy         = (r_state == WAIT);
    assign o_pass         = (r_result == PASS);
    assign o_err_early    = (r_result == EARLY);
    assign o_err_timeout  = (r_result == TIMEOUT);
    assign o_err_spurious = (r_result == SPURIOUS);

endmodule : req_gnt_mon_ch
`default_nettype wire

// File: rtl/req_gnt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : req_gnt_monitor
// Description : Multi-channel request/grant latency monitor. Each channel is
//               checked by its own req_gnt_mon_ch instance; this level keeps
//               the per-channel sticky error flags and, optionally, saturating
//               pass/fail event counters.
// Config      : define REQ_GNT_MONITOR_STATS_EN to build pass_cnt / fail_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_monitor
    import req_gnt_mon_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,        // synchronous, active-low
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] gnt,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] pass,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] err_timeout,
    output logic [NUM_CH-1:0] err_spurious,
    output logic [NUM_CH-1:0] err_sticky
`ifdef REQ_GNT_MONITOR_STATS_EN
    ,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
`endif
);

    // Reject parameter sets the channel logic was not built for
    if (NUM_CH < 1 || NUM_CH > 32 || MAX_LAT < 1 || MIN_LAT < 0 ||
        MIN_LAT > MAX_LAT || CNT_W < 1) begin : g_param_check
        $error("req_gnt_monitor: illegal parameter combination");
    end

    logic [NUM_CH-1:0] w_err_now;
    logic [NUM_CH-1:0] r_sticky;

    // One independent checker per channel
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_gnt_mon_ch #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .i_req          (req[g]),
            .i_gnt          (gnt[g]),
            .o_busy         (busy[g]),
            .o_pass         (pass[g]),
            .o_err_early    (err_early[g]),
            .o_err_timeout  (err_timeout[g]),
            .o_err_spurious (err_spurious[g])
        );
    end

    assign w_err_now = err_early | err_timeout | err_spurious;

    // Sticky flags remember every error pulse until the next reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= r_sticky | w_err_now;
        end
    end

    // Including the live pulse makes the flag rise together with the pulse
    assign err_sticky = r_sticky | w_err_now;

`ifdef REQ_GNT_MONITOR_STATS_EN
    // Six guard bits hold the carry of adding up to 32 events per cycle
    localparam int c_SUM_W = CNT_W + 6;

    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [c_SUM_W-1:0] w_pass_sum;
    logic [c_SUM_W-1:0] w_fail_sum;

    assign w_pass_sum = c_SUM_W'(r_pass_cnt) + c_SUM_W'(popcount32(32'(pass)));
    assign w_fail_sum = c_SUM_W'(r_fail_cnt) + c_SUM_W'(popcount32(32'(w_err_now)));

    // Event counters: any carry into the guard bits pins the count at all-ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_pass_cnt <= (|w_pass_sum[c_SUM_W-1:CNT_W]) ? '1 : w_pass_sum[CNT_W-1:0];
            r_fail_cnt <= (|w_fail_sum[c_SUM_W-1:CNT_W]) ? '1 : w_fail_sum[CNT_W-1:0];
        end
    end

    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;
`endif

endmodule : req_gnt_monitor
`default_nettype wire

// File: tb/tb_req_gnt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_gnt_monitor
// Description : Self-checking bench for req_gnt_monitor (3 channels, latency
//               window 3..5). A cycle-numbered reference model predicts every
//               output; directed scenarios add literal expectations, followed
//               by a randomized req/gnt/reset run.
// Config      : counter checks are built when REQ_GNT_MONITOR_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_gnt_monitor;

    localparam int NCH  = 3;
    localparam int MINL = 3;
    localparam int MAXL = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] req, gnt;
    logic [NCH-1:0] busy, pass, err_early, err_timeout, err_spurious, err_sticky;

    always #5 clk = ~clk;

`ifdef REQ_GNT_MONITOR_STATS_EN
    logic [15:0]    pass_cnt, fail_cnt;
    logic [NCH-1:0] s_busy, s_pass, s_early, s_timeout, s_spurious, s_sticky;
    logic [2:0]     s_pass_cnt, s_fail_cnt;
`endif

    req_gnt_monitor #(
        .NUM_CH (NCH), .MIN_LAT (MINL), .MAX_LAT (MAXL), .CNT_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .gnt          (gnt),
        .busy         (busy),
        .pass         (pass),
        .err_early    (err_early),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious),
        .err_sticky   (err_sticky)
`ifdef REQ_GNT_MONITOR_STATS_EN
        ,
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
`endif
    );

`ifdef REQ_GNT_MONITOR_STATS_EN
    // Narrow-counter copy so saturation is reached within a short run
    req_gnt_monitor #(
        .NUM_CH (NCH), .MIN_LAT (MINL), .MAX_LAT (MAXL), .CNT_W (3)
    ) dut_small (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .gnt          (gnt),
        .busy         (s_busy),
        .pass         (s_pass),
        .err_early    (s_early),
        .err_timeout  (s_timeout),
        .err_spurious (s_spurious),
        .err_sticky   (s_sticky),
        .pass_cnt     (s_pass_cnt),
        .fail_cnt     (s_fail_cnt)
    );
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state: outstanding flag and the cycle the request was taken
    int             cyc = 0;
    bit             m_busy  [NCH];
    int             m_start [NCH];
    logic [NCH-1:0] e_busy, e_pass, e_early, e_timeout, e_spurious, e_sticky;
    int             e_pcnt, e_fcnt, e_pcnt_s, e_fcnt_s;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_add(input int a, input int b, input int maxv);
        return (a + b > maxv) ? maxv : a + b;
    endfunction

    // Predict the outputs that follow the sample taken at this edge
    task automatic model_edge();
        int k;
        cyc++;
        if (!reset) begin
            for (int c = 0; c < NCH; c++) m_busy[c] = 1'b0;
            e_pass = '0; e_early = '0; e_timeout = '0; e_spurious = '0;
            e_sticky = '0;
            e_pcnt = 0; e_fcnt = 0; e_pcnt_s = 0; e_fcnt_s = 0;
        end else begin
            // Counters absorb the events that were visible before this edge
            e_pcnt   = sat_add(e_pcnt,   $countones(e_pass), 65535);
            e_pcnt_s = sat_add(e_pcnt_s, $countones(e_pass), 7);
            e_fcnt   = sat_add(e_fcnt,   $countones(e_early | e_timeout | e_spurious), 65535);
            e_fcnt_s = sat_add(e_fcnt_s, $countones(e_early | e_timeout | e_spurious), 7);
            e_pass = '0; e_early = '0; e_timeout = '0; e_spurious = '0;
            for (int c = 0; c < NCH; c++) begin
                if (!m_busy[c]) begin
                    if (req[c] && gnt[c]) begin
                        if (MINL == 0) e_pass[c] = 1'b1; else e_early[c] = 1'b1;
                    end else if (req[c]) begin
                        m_busy[c]  = 1'b1;
                        m_start[c] = cyc;
                    end else if (gnt[c]) begin
                        e_spurious[c] = 1'b1;
                    end
                end else begin
                    k = cyc - m_start[c];
                    if (gnt[c]) begin
                        if (k >= MINL && k <= MAXL) e_pass[c] = 1'b1; else e_early[c] = 1'b1;
                        m_busy[c] = 1'b0;
                    end else if (k == MAXL) begin
                        e_timeout[c] = 1'b1;
                        m_busy[c]    = 1'b0;
                    end
                end
            end
            e_sticky = e_sticky | e_early | e_timeout | e_spurious;
        end
        for (int c = 0; c < NCH; c++) e_busy[c] = m_busy[c];
    endtask

    // Present one cycle of inputs, clock it, advance the model
    task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] g, input logic rn);
        #2;
        req   = r;
        gnt   = g;
        reset = rn;
        @(posedge clk);
        model_edge();
    endtask

    // Every-cycle comparison of the DUT against the model, away from the edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",         32'(busy),         32'(e_busy));
            check("pass",         32'(pass),         32'(e_pass));
            check("err_early",    32'(err_early),    32'(e_early));
            check("err_timeout",  32'(err_timeout),  32'(e_timeout));
            check("err_spurious", 32'(err_spurious), 32'(e_spurious));
            check("err_sticky",   32'(err_sticky),   32'(e_sticky));
`ifdef REQ_GNT_MONITOR_STATS_EN
            check("pass_cnt",     32'(pass_cnt),     32'(e_pcnt));
            check("fail_cnt",     32'(fail_cnt),     32'(e_fcnt));
            check("s_pass_cnt",   32'(s_pass_cnt),   32'(e_pcnt_s));
            check("s_fail_cnt",   32'(s_fail_cnt),   32'(e_fcnt_s));
`endif
        end
    end

    initial begin
        reset = 1'b0; req = '0; gnt = '0;
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        chk_en = 1'b1;
        #1;
        check("rst_busy",   32'(busy),       32'h0);
        check("rst_sticky", 32'(err_sticky), 32'h0);
`ifdef REQ_GNT_MONITOR_STATS_EN
        check("rst_pass_cnt", 32'(pass_cnt), 32'h0);
`endif

        // Channel 0: grant at latency 4 -> pass
        step(3'b001, 3'b000, 1'b1); #1 check("c0_busy_T1", 32'(busy[0]), 32'h1);
        repeat (3) step(3'b000, 3'b000, 1'b1);
        #1 check("c0_busy_T4", 32'(busy[0]), 32'h1);
        step(3'b000, 3'b001, 1'b1);
        #1 check("c0_pass", 32'(pass[0]), 32'h1);
        check("c0_busy_after", 32'(busy[0]), 32'h0);
        step(3'b000, 3'b000, 1'b1);
`ifdef REQ_GNT_MONITOR_STATS_EN
        #1 check("c0_pass_cnt", 32'(pass_cnt), 32'h1);
`endif

        // Channel 1: grant at latency 1 -> early
        step(3'b010, 3'b000, 1'b1);
        step(3'b000, 3'b010, 1'b1);
        #1 check("c1_early", 32'(err_early[1]), 32'h1);
        check("c1_sticky", 32'(err_sticky[1]), 32'h1);
        step(3'b000, 3'b000, 1'b1);
        #1 check("c1_sticky_held", 32'(err_sticky[1]), 32'h1);
`ifdef REQ_GNT_MONITOR_STATS_EN
        check("c1_fail_cnt", 32'(fail_cnt), 32'h1);
`endif

        // Channel 2: no grant -> timeout after latency 5
        step(3'b100, 3'b000, 1'b1);
        repeat (4) step(3'b000, 3'b000, 1'b1);
        #1 check("c2_no_timeout_yet", 32'(err_timeout[2]), 32'h0);
        step(3'b000, 3'b000, 1'b1);
        #1 check("c2_timeout", 32'(err_timeout[2]), 32'h1);

        // Channel 2: grant exactly at latency 5 -> pass, not timeout
        step(3'b100, 3'b000, 1'b1);
        repeat (4) step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b100, 1'b1);
        #1 check("c2_pass_at_max", 32'(pass[2]), 32'h1);
        check("c2_no_timeout", 32'(err_timeout[2]), 32'h0);

        // Spurious grant, then simultaneous req+gnt
        step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b001, 1'b1);
        #1 check("c0_spurious", 32'(err_spurious[0]), 32'h1);
        step(3'b001, 3'b001, 1'b1);
        #1 check("c0_same_cycle_early", 32'(err_early[0]), 32'h1);
        check("c0_same_cycle_idle", 32'(busy[0]), 32'h0);

        // All three channels pass together, twice (second drives small counter to saturation)
        for (int rep = 0; rep < 2; rep++) begin
            step(3'b111, 3'b000, 1'b1);
            repeat (3) step(3'b000, 3'b000, 1'b1);
            step(3'b000, 3'b111, 1'b1);
            #1 check("all_pass", 32'(pass), 32'h7);
            step(3'b000, 3'b000, 1'b1);
`ifdef REQ_GNT_MONITOR_STATS_EN
            #1;
            if (rep == 0) begin
                check("all_pass_cnt",   32'(pass_cnt),   32'd5);
                check("all_fail_cnt",   32'(fail_cnt),   32'd4);
                check("s_all_pass_cnt", 32'(s_pass_cnt), 32'd5);
            end else begin
                check("all_pass_cnt2",  32'(pass_cnt),   32'd8);
                check("s_pass_cnt_sat", 32'(s_pass_cnt), 32'd7);
            end
`endif
        end

        // Reset in the middle of a wait abandons the request silently
        step(3'b001, 3'b000, 1'b1);
        step(3'b000, 3'b000, 1'b1);
        #1 check("rw_busy_before", 32'(busy[0]), 32'h1);
        step(3'b000, 3'b000, 1'b0);
        #1 check("rw_busy", 32'(busy), 32'h0);
        check("rw_sticky", 32'(err_sticky), 32'h0);
        check("rw_no_pulse", 32'(pass | err_early | err_timeout | err_spurious), 32'h0);
        step(3'b001, 3'b000, 1'b1);
        repeat (3) step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b001, 1'b1);
        #1 check("rw_resume_pass", 32'(pass[0]), 32'h1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic [NCH-1:0] r, g;
            for (int c = 0; c < NCH; c++) begin
                r[c] = ($urandom_range(0, 2) == 0);
                g[c] = ($urandom_range(0, 3) == 0);
            end
            step(r, g, ($urandom_range(0, 299) != 0));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_req_gnt_monitor
`default_nettype wire
